// File: rtl/txt_console_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : txt_pkg
//  Purpose  : Shared constants, control codes and state type for the text
//             console write path (txt_console, txt_cell_addr).
//  Contents : TXT_COLS/ROWS/CELLS, TXT_BLANK, TXT_CR/LF/BS/FF, txt_state_t
//  Revision : 1.0  initial release
// ============================================================================
package txt_pkg;

    localparam int          TXT_COLS  = 40;
    localparam int          TXT_ROWS  = 30;
    localparam int          TXT_CELLS = TXT_COLS * TXT_ROWS;
    localparam logic [7:0]  TXT_BLANK = 8'h20;

    localparam logic [7:0]  TXT_CR    = 8'h0D;
    localparam logic [7:0]  TXT_LF    = 8'h0A;
    localparam logic [7:0]  TXT_BS    = 8'h08;
    localparam logic [7:0]  TXT_FF    = 8'h0C;

    typedef enum logic [2:0] {
        CLEAR     = 3'd0,
        IDLE      = 3'd1,
        EXEC      = 3'd2,
        SCR_RD    = 3'd3,
        SCR_WR    = 3'd4,
        SCR_BLANK = 3'd5
    } txt_state_t;

endpackage
`default_nettype wire

// File: rtl/txt_console_if.sv
`default_nettype none
// ============================================================================
//  Module   : txt_console_if
//  Purpose  : Byte-stream handshake plus display-memory write/read port of
//             the text console.
//  Signals  : char_in/char_valid/char_ready  - CPU byte stream
//             mem_addr/mem_wdat/mem_we       - display memory write port
//             mem_re/mem_rdat                - display memory read (scroll)
//  Modports : slave  - the console
//             master - CPU side and display memory
//  Revision : 1.0  initial release
// ============================================================================
interface txt_console_if;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdat;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdat;

    modport slave (
        input  char_in, char_valid, mem_rdat,
        output char_ready, mem_addr, mem_wdat, mem_we, mem_re
    );

    modport master (
        output char_in, char_valid, mem_rdat,
        input  char_ready, mem_addr, mem_wdat, mem_we, mem_re
    );
endinterface
`default_nettype wire

// File: rtl/txt_console_cell_addr.sv
`default_nettype none
// ============================================================================
//  Module   : txt_cell_addr
//  Purpose  : Combinational (x,y) -> display cell address, x + 40*y, built
//             as x + (y<<5) + (y<<3). The renderer uses the same form so
//             both sides agree on cell layout.
//  Ports    : x_i    [5:0]  column 0..39
//             y_i    [4:0]  row 0..29
//             addr_o [11:0] cell address 0..1199
//  Revision : 1.0  initial release
// ============================================================================
module txt_cell_addr (
    input  logic [5:0]  x_i,
    input  logic [4:0]  y_i,
    output logic [11:0] addr_o
);
    assign addr_o = {6'd0, x_i} + {2'd0, y_i, 5'd0} + {4'd0, y_i, 3'd0};
endmodule
`default_nettype wire

// File: rtl/txt_console.sv
`default_nettype none
// ============================================================================
//  Module   : txt_console
//  Purpose  : Character-stream front end of the text display. Accepts one
//             byte per handshake, writes printable characters at the cursor,
//             interprets CR/LF/BS/FF, clears and scrolls/wraps the screen.
//  Ports    : clk, clr          - clock, synchronous active-high reset
//             bus (slave)       - byte stream + display memory port
//             cursor_x/cursor_y - current cursor column/row
//             busy              - clear, scroll or row blank in progress
//  Config   : TXT_SCROLL_EN defined   -> LF past the last row scrolls up
//             TXT_SCROLL_EN undefined -> cursor wraps to row 0, row 0 blanked
//  Revision : 1.0  initial release
// ============================================================================
module txt_console
    import txt_pkg::*;
#(
    parameter int COLS = 40,
    parameter int ROWS = 30
) (
    input  logic              clk,
    input  logic              clr,
    txt_console_if.slave      bus,
    output logic [5:0]        cursor_x,
    output logic [4:0]        cursor_y,
    output logic              busy
);

    localparam logic [5:0]  c_xmax       = 6'(COLS - 1);
    localparam logic [4:0]  c_ymax       = 5'(ROWS - 1);
    localparam logic [11:0] c_cols       = 12'(COLS);
    localparam logic [11:0] c_last_cell  = 12'(COLS * ROWS - 1);
`ifdef TXT_SCROLL_EN
    localparam logic [11:0] c_last_move  = 12'(COLS * (ROWS - 1) - 1);
    localparam logic [11:0] c_blank_last = c_last_cell;
`else
    localparam logic [11:0] c_blank_last = 12'(COLS - 1);
`endif

    txt_state_t  state_q, state_d;
    logic [5:0]  x_q, x_d;
    logic [4:0]  y_q, y_d;
    logic [11:0] cnt_q, cnt_d;
    logic [7:0]  byte_q, byte_d;

    logic [11:0] w_cur_addr;
    logic        w_ready, w_we, w_re, w_busy, w_adv;
    logic [11:0] w_addr;
    logic [7:0]  w_wdat;

    txt_cell_addr u_cell_addr (
        .x_i    (x_q),
        .y_i    (y_q),
        .addr_o (w_cur_addr)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= CLEAR;
            x_q     <= 6'd0;
            y_q     <= 5'd0;
            cnt_q   <= 12'd0;
            byte_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        w_ready = 1'b0;
        w_we    = 1'b0;
        w_re    = 1'b0;
        w_busy  = 1'b0;
        w_adv   = 1'b0;
        w_addr  = 12'd0;
        w_wdat  = TXT_BLANK;

        case (state_q)
            CLEAR: begin
                w_busy = 1'b1;
                w_we   = 1'b1;
                w_addr = cnt_q;
                x_d    = 6'd0;
                y_d    = 5'd0;
                if (cnt_q == c_last_cell) begin
                    state_d = IDLE;
                    cnt_d   = 12'd0;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end

            IDLE: begin
                w_ready = 1'b1;
                if (bus.char_valid) begin
                    byte_d  = bus.char_in;
                    state_d = EXEC;
                end
            end

            EXEC: begin
                state_d = IDLE;
                if (byte_q >= TXT_BLANK && byte_q <= 8'h7E) begin
                    // Write lands at the pre-advance cursor.
                    w_we   = 1'b1;
                    w_addr = w_cur_addr;
                    w_wdat = byte_q;
                    if (x_q == c_xmax) begin
                        x_d   = 6'd0;
                        w_adv = 1'b1;
                    end else begin
                        x_d = x_q + 6'd1;
                    end
                end else if (byte_q == TXT_CR) begin
                    x_d = 6'd0;
                end else if (byte_q == TXT_LF) begin
                    w_adv = 1'b1;
                end else if (byte_q == TXT_BS) begin
                    if (x_q != 6'd0) begin
                        x_d = x_q - 6'd1;
                    end
                end else if (byte_q == TXT_FF) begin
                    state_d = CLEAR;
                    cnt_d   = 12'd0;
                    x_d     = 6'd0;
                    y_d     = 5'd0;
                end

                if (w_adv) begin
                    if (y_q != c_ymax) begin
                        y_d = y_q + 5'd1;
                    end else begin
`ifdef TXT_SCROLL_EN
                        state_d = SCR_RD;
                        cnt_d   = 12'd0;
`else
                        y_d     = 5'd0;
                        state_d = SCR_BLANK;
                        cnt_d   = 12'd0;
`endif
                    end
                end
            end

`ifdef TXT_SCROLL_EN
            // Read the cell one row below; its data returns next cycle.
            SCR_RD: begin
                w_busy  = 1'b1;
                w_re    = 1'b1;
                w_addr  = cnt_q + c_cols;
                state_d = SCR_WR;
            end

            SCR_WR: begin
                w_busy = 1'b1;
                w_we   = 1'b1;
                w_addr = cnt_q;
                w_wdat = bus.mem_rdat;
                cnt_d  = cnt_q + 12'd1;
                if (cnt_q == c_last_move) begin
                    state_d = SCR_BLANK;
                end else begin
                    state_d = SCR_RD;
                end
            end
`endif

            SCR_BLANK: begin
                w_busy = 1'b1;
                w_we   = 1'b1;
                w_addr = cnt_q;
                if (cnt_q == c_blank_last) begin
                    state_d = IDLE;
                    cnt_d   = 12'd0;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end

            default: begin
                state_d = CLEAR;
                cnt_d   = 12'd0;
            end
        endcase

        // While clr is held the outputs show their reset values rather
        // than whatever the pre-reset state would drive.
        if (clr) begin
            w_ready = 1'b0;
            w_we    = 1'b0;
            w_re    = 1'b0;
            w_busy  = 1'b1;
            w_addr  = 12'd0;
            w_wdat  = TXT_BLANK;
        end
    end

`ifndef TXT_SCROLL_EN
    logic w_unused_rdat;
    assign w_unused_rdat = ^bus.mem_rdat;
`endif

    assign bus.char_ready = w_ready;
    assign bus.mem_we     = w_we;
    assign bus.mem_re     = w_re;
    assign bus.mem_addr   = w_addr;
    assign bus.mem_wdat   = w_wdat;
    assign cursor_x       = x_q;
    assign cursor_y       = y_q;
    assign busy           = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_txt_console.sv
`default_nettype none
// ============================================================================
//  Module   : tb_txt_console
//  Purpose  : Self-checking bench for txt_console: directed steps plus a
//             randomized byte stream checked against a screen/cursor model.
//  Config   : honours TXT_SCROLL_EN for scroll vs wrap expectations
//  Revision : 1.0  initial release
// ============================================================================
module tb_txt_console;

    logic       clk;
    logic       clr;
    logic [5:0] cursor_x;
    logic [4:0] cursor_y;
    logic       busy;

    txt_console_if bus ();

    txt_console #(.COLS(40), .ROWS(30)) dut (
        .clk      (clk),
        .clr      (clr),
        .bus      (bus.slave),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Display memory: write port plus registered read port.
    logic [7:0] dmem [0:1199];
    logic [7:0] rdat_r;
    always @(posedge clk) begin
        if (bus.mem_we && bus.mem_addr < 12'd1200) dmem[bus.mem_addr] <= bus.mem_wdat;
        if (bus.mem_re && bus.mem_addr < 12'd1200) rdat_r <= dmem[bus.mem_addr];
    end
    assign bus.mem_rdat = rdat_r;

    // Reference screen model.
    logic [7:0] exp_mem [0:1199];
    int ex, ey;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_blank(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) exp_mem[a] = 8'h20;
    endtask

    task automatic model_step(input logic [7:0] b, output bit ew, output int ea, output int eb);
        bit adv;
        adv = 0; ew = 0; ea = 0; eb = 0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            ew = 1;
            ea = ey * 40 + ex;
            exp_mem[ea] = b;
            ex = ex + 1;
            if (ex == 40) begin ex = 0; adv = 1; end
        end else if (b == 8'h0D) ex = 0;
        else if (b == 8'h0A) adv = 1;
        else if (b == 8'h08) begin if (ex > 0) ex = ex - 1; end
        else if (b == 8'h0C) begin
            model_blank(0, 1199);
            ex = 0; ey = 0; eb = 1200;
        end
        if (adv) begin
            if (ey < 29) ey = ey + 1;
            else begin
`ifdef TXT_SCROLL_EN
                for (int r = 0; r < 29; r++)
                    for (int c = 0; c < 40; c++)
                        exp_mem[r*40 + c] = exp_mem[(r+1)*40 + c];
                model_blank(1160, 1199);
                eb = 2360;
`else
                ey = 0;
                model_blank(0, 39);
                eb = 40;
`endif
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n; bit ew; int ea; int eb;
        n = 0;
        while (!bus.char_ready && n < 6000) begin @(negedge clk); #1; n++; end
        chk("ready_wait", bus.char_ready, 1);
        bus.char_in = b;
        bus.char_valid = 1'b1;
        model_step(b, ew, ea, eb);
        @(negedge clk); #1;
        bus.char_valid = 1'b0;
        chk("exec_ready", bus.char_ready, 0);
        chk("exec_we", bus.mem_we, ew);
        if (ew) begin
            chk("exec_addr", bus.mem_addr, ea);
            chk("exec_wdat", bus.mem_wdat, b);
        end
        @(negedge clk); #1;
        n = 0;
        while (!bus.char_ready && n < 3000) begin n++; @(negedge clk); #1; end
        chk("busy_cycles", n, eb);
        chk("busy_at_ready", busy, 0);
        chk("cursor_x", cursor_x, ex);
        chk("cursor_y", cursor_y, ey);
    endtask

    task automatic check_mem(input string tag);
        int bad; int first;
        bad = 0; first = -1;
        for (int i = 0; i < 1200; i++)
            if (dmem[i] !== exp_mem[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        if (first >= 0) $display("first differing cell %0d: %0h vs %0h", first, dmem[first], exp_mem[first]);
        chk(tag, bad, 0);
    endtask

    initial begin
        int n; int bad; int r; bit ew; int ea; int eb;
        logic [7:0] b;

        clr = 1'b1;
        bus.char_in = 8'h00;
        bus.char_valid = 1'b0;
        ex = 0; ey = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", bus.char_ready, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_re", bus.mem_re, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdat", bus.mem_wdat, 8'h20);
        chk("rst_cx", cursor_x, 0);
        chk("rst_cy", cursor_y, 0);
        chk("rst_busy", busy, 1);

        // Release: 1200 blank writes in order, then ready.
        clr = 1'b0;
        bad = 0;
        for (int i = 0; i < 1200; i++) begin
            #1;
            if (!(bus.mem_we === 1'b1 && bus.mem_addr === 12'(i) && bus.mem_wdat === 8'h20 &&
                  bus.char_ready === 1'b0 && busy === 1'b1)) bad++;
            @(negedge clk);
        end
        #1;
        chk("clear_seq_bad", bad, 0);
        chk("clear_ready_1200", bus.char_ready, 1);
        chk("clear_busy_off", busy, 0);
        chk("clear_cx", cursor_x, 0);
        chk("clear_cy", cursor_y, 0);
        model_blank(0, 1199);
        check_mem("mem_after_clear");

        // Directed: A, B, then position and pre-load cell 45.
        send(8'h41);
        send(8'h42);
        send(8'h0D); send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
        send(8'h51);
        send(8'h0D);
        for (int i = 0; i < 4; i++) send(8'h0A);
        for (int i = 0; i < 39; i++) send(8'h2E);
        chk("at_39_5_x", cursor_x, 39);
        send(8'h58);
        chk("wrap_cx", cursor_x, 0);
        chk("wrap_cy", cursor_y, 6);
        chk("cell_239", dmem[239], 8'h58);
        send(8'h0D);
        send(8'h08);
        for (int i = 0; i < 23; i++) send(8'h0A);
        chk("at_row29", cursor_y, 29);
        send(8'h0A);
`ifdef TXT_SCROLL_EN
        chk("scroll_cell5", dmem[5], 8'h51);
        chk("scroll_cy", cursor_y, 29);
        chk("scroll_cell1199", dmem[1199], 8'h20);
`else
        chk("wrap_cell5", dmem[5], 8'h20);
        chk("wrap_cy0", cursor_y, 0);
        chk("wrap_cell45", dmem[45], 8'h51);
`endif
        check_mem("mem_after_row_adv");

        // Randomized stream against the model.
        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 99);
            if (r < 78)      b = 8'($urandom_range(32, 126));
            else if (r < 84) b = 8'h0D;
            else if (r < 90) b = 8'h08;
            else if (r < 93) b = 8'h0A;
            else if (r < 99) begin
                case ($urandom_range(0, 3))
                    0:       b = 8'h00;
                    1:       b = 8'h1B;
                    2:       b = 8'h7F;
                    default: b = 8'h80 | 8'($urandom_range(0, 127));
                endcase
            end else         b = 8'h0C;
            send(b);
        end
        check_mem("mem_after_random");

        // Form feed at (10,10).
        send(8'h0C);
        for (int i = 0; i < 10; i++) send(8'h0A);
        for (int i = 0; i < 10; i++) send(8'h20);
        chk("at_10_10_x", cursor_x, 10);
        chk("at_10_10_y", cursor_y, 10);
        send(8'h0C);
        check_mem("mem_after_ff");

        // clr in the middle of a clear restarts from address 0.
        bus.char_in = 8'h0C;
        bus.char_valid = 1'b1;
        model_step(8'h0C, ew, ea, eb);
        @(negedge clk); #1;
        bus.char_valid = 1'b0;
        @(negedge clk); #1;
        n = 0;
        while (bus.mem_addr != 12'd600 && n < 2000) begin n++; @(negedge clk); #1; end
        chk("mid_clear_addr", bus.mem_addr, 600);
        clr = 1'b1;
        #1;
        chk("mid_rst_we", bus.mem_we, 0);
        chk("mid_rst_busy", busy, 1);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("restart_we", bus.mem_we, 1);
        chk("restart_addr", bus.mem_addr, 0);
        n = 0;
        while (!bus.char_ready && n < 3000) begin n++; @(negedge clk); #1; end
        chk("restart_cycles", n, 1200);
        chk("restart_cx", cursor_x, 0);
        chk("restart_cy", cursor_y, 0);
        check_mem("mem_after_restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
